// File: rtl/multi_pump_filter_ctrl.sv
// Multi-channel pump controller: REQ/ACK command link, debounced float sensors, level interlock and PWM.
// Build option: define SOFT_START_EN to add the prescaled per-channel duty ramp.
module multi_pump_filter_ctrl #(
    parameter int N_CH         = 2,
    parameter int DUTY_W       = 8,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int RAMP_DIV     = 50_000,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CH_W+DUTY_W-1:0] cmd_data,
    input  logic                   cmd_req,
    output logic                   cmd_ack,
    output logic                   cmd_err,
    input  logic [N_CH-1:0]        level_src,
    input  logic [N_CH-1:0]        level_dst,
    output logic [N_CH-1:0]        pwm_out,
    output logic [N_CH-1:0]        fault,
    output logic [N_CH-1:0]        busy
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};
    localparam logic [CH_W:0] N_CH_L = N_CH[CH_W:0];
    // Debounced sensors power up in the interlocked state: source EMPTY, destination FULL.
    localparam logic [2*N_CH-1:0] SENS_RST = {{N_CH{1'b0}}, {N_CH{1'b1}}};

    if (N_CH < 1 || N_CH > 8 || DUTY_W < 2 || DEBOUNCE_CYC < 1 || RAMP_DIV < 1) begin : g_bad_param
        $error("multi_pump_filter_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LATCH = 2'd1, S_ACK = 2'd2} state_t;

    state_t             state_q, state_d;
    logic               req_meta_q, req_sync_q;
    logic               ack_q, ack_d, err_q, err_d;
    logic               wr_en_s;
    logic [CH_W-1:0]    cmd_ch_s;
    logic [DUTY_W-1:0]  cmd_duty_s;
    logic               cmd_ch_ok_s;
    logic [2*N_CH-1:0]  sens_raw_s, sens_db_s;
    logic [N_CH-1:0]    src_empty_s, dst_full_n_s;
    logic [N_CH-1:0]    fault_d, fault_q;
    logic [DUTY_W-1:0]  pwm_cnt_q;

    assign cmd_ch_s    = cmd_data[CH_W+DUTY_W-1:DUTY_W];
    assign cmd_duty_s  = cmd_data[DUTY_W-1:0];
    assign cmd_ch_ok_s = ({1'b0, cmd_ch_s} < N_CH_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_meta_q <= 1'b0;
            req_sync_q <= 1'b0;
        end else begin
            req_meta_q <= cmd_req;
            req_sync_q <= req_meta_q;
        end
    end

    // Handshake state register together with its registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_sync_q) state_d = S_LATCH; else state_d = S_IDLE;
            S_LATCH: state_d = S_ACK;
            S_ACK:   if (!req_sync_q) state_d = S_IDLE; else state_d = S_ACK;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture happens on the LATCH->ACK edge, so target write, ack and err share that edge.
    always_comb begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        wr_en_s = 1'b0;
        case (state_q)
            S_LATCH: begin
                ack_d   = 1'b1;
                err_d   = !cmd_ch_ok_s;
                wr_en_s = cmd_ch_ok_s;
            end
            S_ACK:   ack_d = req_sync_q;
            default: ack_d = 1'b0;
        endcase
    end

    assign cmd_ack = ack_q;
    assign cmd_err = err_q;

    assign sens_raw_s = {level_dst, level_src};

    for (genvar i = 0; i < 2 * N_CH; i++) begin : g_deb
        logic            meta_q, sync_q, db_q;
        logic [DB_W-1:0] cnt_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                meta_q <= SENS_RST[i];
                sync_q <= SENS_RST[i];
                db_q   <= SENS_RST[i];
                cnt_q  <= '0;
            end else begin
                meta_q <= sens_raw_s[i];
                sync_q <= meta_q;
                if (sync_q == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                    db_q  <= sync_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + DB_W'(1);
                end
            end
        end

        assign sens_db_s[i] = db_q;
    end

    assign src_empty_s  = sens_db_s[N_CH-1:0];
    assign dst_full_n_s = sens_db_s[2*N_CH-1:N_CH];
    assign fault_d      = ~(~src_empty_s & dst_full_n_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q   <= {N_CH{1'b1}};
            pwm_cnt_q <= '0;
        end else begin
            fault_q   <= fault_d;
            pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
        end
    end

    assign fault = fault_q;

`ifdef SOFT_START_EN
    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    logic [PRE_W-1:0] pre_q;
    logic             ramp_tick_s;

    assign ramp_tick_s = (pre_q == PRE_W'(RAMP_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else if (ramp_tick_s) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DUTY_W-1:0] target_q, target_d, applied_q, applied_d;
        logic              busy_q, busy_d, pwm_q, pwm_d;

        always_comb begin
            if (wr_en_s && (cmd_ch_s == CH_W'(c))) begin
                target_d = cmd_duty_s;
            end else begin
                target_d = target_q;
            end
        end

`ifdef SOFT_START_EN
        // Interlock wins over the ramp; a later clear therefore ramps up from zero.
        always_comb begin
            if (fault_q[c]) begin
                applied_d = '0;
            end else if (ramp_tick_s && (applied_q < target_q)) begin
                applied_d = applied_q + DUTY_W'(1);
            end else if (ramp_tick_s && (applied_q > target_q)) begin
                applied_d = applied_q - DUTY_W'(1);
            end else begin
                applied_d = applied_q;
            end
        end
        assign busy_d = (applied_d != target_d) && !fault_d[c];
`else
        assign applied_d = fault_q[c] ? '0 : target_q;
        assign busy_d    = 1'b0;
`endif

        assign pwm_d = !fault_q[c] && ((applied_q == DUTY_MAX) || (pwm_cnt_q < applied_q));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                target_q  <= '0;
                applied_q <= '0;
                busy_q    <= 1'b0;
                pwm_q     <= 1'b0;
            end else begin
                target_q  <= target_d;
                applied_q <= applied_d;
                busy_q    <= busy_d;
                pwm_q     <= pwm_d;
            end
        end

        assign pwm_out[c] = pwm_q;
        assign busy[c]    = busy_q;
    end

endmodule

// File: tb/tb_multi_pump_filter_ctrl.sv
// Directed bench for multi_pump_filter_ctrl: a 2-channel and a 3-channel instance on one clock.
module tb_multi_pump_filter_ctrl;

`ifdef SOFT_START_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [8:0] a_data;
    logic       a_req, a_ack, a_err;
    logic [1:0] a_src, a_dst, a_pwm, a_fault, a_busy;
    logic [9:0] b_data;
    logic       b_req, b_ack, b_err;
    logic [2:0] b_src, b_dst, b_pwm, b_fault, b_busy;

    int         n_checks;
    int         n_errors;
    int         pwm_a [2];
    int         pwm_b [3];
    logic [1:0] busy_at_ack;

    multi_pump_filter_ctrl #(.N_CH(2), .DUTY_W(8), .DEBOUNCE_CYC(4), .RAMP_DIV(2)) u_dut_a (
        .clk(clk), .reset(reset), .cmd_data(a_data), .cmd_req(a_req), .cmd_ack(a_ack),
        .cmd_err(a_err), .level_src(a_src), .level_dst(a_dst), .pwm_out(a_pwm),
        .fault(a_fault), .busy(a_busy)
    );

    multi_pump_filter_ctrl #(.N_CH(3), .DUTY_W(8), .DEBOUNCE_CYC(4), .RAMP_DIV(2)) u_dut_b (
        .clk(clk), .reset(reset), .cmd_data(b_data), .cmd_req(b_req), .cmd_ack(b_ack),
        .cmd_err(b_err), .level_src(b_src), .level_dst(b_dst), .pwm_out(b_pwm),
        .fault(b_fault), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cmd(input bit on_b, input int ch, input int duty, input int exp_err,
                            input string tag);
        int   err_cnt;
        int   err_rise;
        int   waited;
        logic ack_now;
        err_cnt = 0;
        if (on_b) begin
            b_data = {2'(ch), 8'(duty)};
            b_req  = 1'b1;
        end else begin
            a_data = {1'(ch), 8'(duty)};
            a_req  = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            err_cnt += on_b ? int'(b_err) : int'(a_err);
        end
        check_eq({tag, "_ack_early"}, on_b ? int'(b_ack) : int'(a_ack), 0);
        cyc(1);
        check_eq({tag, "_ack_rise"}, on_b ? int'(b_ack) : int'(a_ack), 1);
        err_rise    = on_b ? int'(b_err) : int'(a_err);
        err_cnt    += err_rise;
        busy_at_ack = a_busy;
        check_eq({tag, "_err_at_ack"}, err_rise, exp_err);
        if (on_b) b_req = 1'b0;
        else      a_req = 1'b0;
        waited  = 0;
        ack_now = 1'b1;
        while (ack_now && waited < 20) begin
            cyc(1);
            waited++;
            ack_now  = on_b ? b_ack : a_ack;
            err_cnt += on_b ? int'(b_err) : int'(a_err);
        end
        check_eq({tag, "_ack_fall"}, int'(ack_now), 0);
        check_eq({tag, "_err_pulses"}, err_cnt, exp_err);
    endtask

    task automatic settle(input string tag);
        int waited;
        waited = 0;
        while ((a_busy != 2'b00 || b_busy != 3'b000) && waited < 2000) begin
            cyc(1);
            waited++;
        end
        check_eq({tag, "_settle"}, int'(a_busy != 2'b00 || b_busy != 3'b000), 0);
        cyc(3);
    endtask

    // One full PWM period: the high-cycle count equals the applied duty.
    task automatic measure();
        for (int c = 0; c < 2; c++) pwm_a[c] = 0;
        for (int c = 0; c < 3; c++) pwm_b[c] = 0;
        repeat (256) begin
            cyc(1);
            for (int c = 0; c < 2; c++) pwm_a[c] += int'(a_pwm[c]);
            for (int c = 0; c < 3; c++) pwm_b[c] += int'(b_pwm[c]);
        end
    endtask

    task automatic glitch_src0(input int len, input int exp_seen, input string tag);
        logic seen;
        seen     = 1'b0;
        a_src[0] = 1'b1;
        repeat (len) begin
            cyc(1);
            seen |= a_fault[0];
        end
        a_src[0] = 1'b0;
        repeat (20) begin
            cyc(1);
            seen |= a_fault[0];
        end
        check_eq({tag, "_fault_seen"}, int'(seen), exp_seen);
        check_eq({tag, "_fault_end"}, int'(a_fault), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        a_req    = 1'b0;
        b_req    = 1'b0;
        a_data   = '0;
        b_data   = '0;
        a_src    = 2'b00;
        a_dst    = 2'b11;
        b_src    = 3'b000;
        b_dst    = 3'b111;
        cyc(2);
        check_eq("rst_ack", int'(a_ack), 0);
        check_eq("rst_err", int'(a_err), 0);
        check_eq("rst_pwm", int'(a_pwm), 0);
        check_eq("rst_busy", int'(a_busy), 0);
        check_eq("rst_fault_a", int'(a_fault), 3);
        check_eq("rst_fault_b", int'(b_fault), 7);
        reset = 1'b0;

        // Two synchroniser flops, four debounce cycles, then the registered fault.
        cyc(6);
        check_eq("deb_fault_held", int'(a_fault), 3);
        cyc(1);
        check_eq("deb_fault_clear_a", int'(a_fault), 0);
        check_eq("deb_fault_clear_b", int'(b_fault), 0);
        check_eq("deb_pwm_zero", int'(a_pwm), 0);

        send_cmd(1'b0, 1, 4, 0, "a_ch1_d4");
        check_eq("a_ch1_busy_at_ack", int'(busy_at_ack[1]), int'(SOFT));
        settle("a_ch1");
        measure();
        check_eq("a_ch1_pwm_d4", pwm_a[1], 4);
        check_eq("a_ch0_pwm_idle", pwm_a[0], 0);

        send_cmd(1'b0, 0, 255, 0, "a_ch0_d255");
        settle("a_ch0_up");
        measure();
        check_eq("a_ch0_pwm_full", pwm_a[0], 256);
        check_eq("a_ch1_pwm_kept", pwm_a[1], 4);

        send_cmd(1'b0, 0, 0, 0, "a_ch0_d0");
        settle("a_ch0_down");
        measure();
        check_eq("a_ch0_pwm_off", pwm_a[0], 0);

        a_dst[1] = 1'b0;
        cyc(6);
        check_eq("a_dst1_fault_early", int'(a_fault), 0);
        cyc(1);
        check_eq("a_dst1_fault", int'(a_fault), 2);
        measure();
        check_eq("a_ch1_pwm_faulted", pwm_a[1], 0);
        check_eq("a_ch1_busy_faulted", int'(a_busy[1]), 0);
        a_dst[1] = 1'b1;
        cyc(6);
        check_eq("a_dst1_fault_hold", int'(a_fault), 2);
        cyc(1);
        check_eq("a_dst1_fault_clear", int'(a_fault), 0);
        check_eq("a_ch1_ramp_restart", int'(a_busy[1]), int'(SOFT));
        settle("a_ch1_restart");
        measure();
        check_eq("a_ch1_pwm_restored", pwm_a[1], 4);

        glitch_src0(3, 0, "glitch3");
        glitch_src0(6, 1, "glitch6");

        send_cmd(1'b1, 2, 7, 0, "b_ch2_d7");
        settle("b_ch2");
        measure();
        check_eq("b_ch2_pwm", pwm_b[2], 7);
        check_eq("b_ch0_pwm", pwm_b[0], 0);
        check_eq("b_ch1_pwm", pwm_b[1], 0);

        send_cmd(1'b1, 3, 99, 1, "b_bad_ch");
        settle("b_bad");
        measure();
        check_eq("b_bad_ch2_pwm", pwm_b[2], 7);
        check_eq("b_bad_ch0_pwm", pwm_b[0], 0);
        check_eq("b_bad_ch1_pwm", pwm_b[1], 0);

        // Asynchronous reset while cmd_ack is high must drop it before the next edge.
        a_data = {1'b0, 8'd9};
        a_req  = 1'b1;
        cyc(5);
        check_eq("mid_hs_ack_high", int'(a_ack), 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_hs_ack_drop", int'(a_ack), 0);
        check_eq("mid_hs_fault", int'(a_fault), 3);
        a_req = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
